// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg : shared constants and types for the audio_in I2S receiver.
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ERR_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/audio_sync.sv
// ============================================================================
// audio_sync : multi-flop synchronizer; one edge-detected input with a
//              rising-edge strobe, plus a plain-synchronized data vector.
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module audio_sync #(
  parameter int W      = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         edge_in,
  input  logic [W-1:0] d,
  output logic         edge_rise,
  output logic [W-1:0] q
);

  logic [STAGES-1:0]        r_edge_pipe;
  logic                     r_edge_prev;
  logic [STAGES-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_pipe <= '0;
      r_edge_prev <= 1'b0;
      r_pipe      <= '0;
    end else begin
      r_edge_pipe <= {r_edge_pipe[STAGES-2:0], edge_in};
      r_edge_prev <= r_edge_pipe[STAGES-1];
      r_pipe      <= {r_pipe[STAGES-2:0], d};
    end
  end

  // Both chains have equal depth, so data is coherent with the strobe.
  assign edge_rise = r_edge_pipe[STAGES-1] & ~r_edge_prev;
  assign q         = r_pipe[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/audio_in.sv
// ============================================================================
// audio_in : oversampled I2S capture into paired signed left/right samples.
//            Optional macro AUDIO_IN_ERR_CNT_EN adds a saturating err_count.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module audio_in
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       BCLK,
  input  logic                       LRCLK,
  input  logic                       ADCDAT,
  output logic signed [SAMPLE_W-1:0] left,
  output logic signed [SAMPLE_W-1:0] right,
  output logic                       valid,
  output logic                       frame_err
`ifdef AUDIO_IN_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_count
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic [1:0]          w_lrdat;
  logic                w_stb;
  logic                w_lr;
  logic                w_dat;

  state_t              r_state;
  state_t              w_next;
  logic                r_lr_prev;
  logic                r_seen;
  logic                r_chan;
  logic [CNT_W-1:0]    r_cnt;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [SAMPLE_W-1:0] r_left_hold;
  logic                r_left_ok;

  logic                w_lr_chg;
  logic                w_fall;
  logic                w_start;
  logic                w_shift;
  logic                w_done;
  logic                w_err;
  logic [SAMPLE_W-1:0] w_word;

  audio_sync #(
    .W      (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (CLK),
    .rst       (RST),
    .edge_in   (BCLK),
    .d         ({ADCDAT, LRCLK}),
    .edge_rise (w_stb),
    .q         (w_lrdat)
  );

  assign w_lr   = w_lrdat[0];
  assign w_dat  = w_lrdat[1];
  assign w_word = {r_shreg[SAMPLE_W-2:0], w_dat};

  assign w_lr_chg = w_stb && (w_lr != r_lr_prev);
  // r_seen keeps the reset value of lr_prev from faking a 1->0 edge mid-slot.
  assign w_fall   = w_stb && r_seen && r_lr_prev && !w_lr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = ST_DELAY;
    end else if (w_done) begin
      w_next = ST_HOLD;
    end else if (w_shift) begin
      w_next = ST_SHIFT;
    end
  end

  // The strobe that reveals an LRCLK change is the I2S delay bit; the first
  // strobe seen in DELAY therefore carries the MSB.
  always_comb begin
    w_start = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = w_fall;
      end
      ST_DELAY, ST_SHIFT: begin
        if (w_lr_chg) begin
          w_start = 1'b1;
          w_err   = 1'b1;
        end else if (w_stb) begin
          w_shift = 1'b1;
          w_done  = (r_cnt == CNT_W'(SAMPLE_W - 1));
        end
      end
      ST_HOLD: begin
        w_start = w_lr_chg;
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lr_prev   <= 1'b1;
      r_seen      <= 1'b0;
      r_chan      <= 1'b0;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      left        <= '0;
      right       <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= w_err;
      if (w_stb) begin
        r_lr_prev <= w_lr;
        r_seen    <= 1'b1;
      end
      if (w_start) begin
        r_chan <= w_lr;
        r_cnt  <= '0;
        if (!w_lr) begin
          r_left_ok <= 1'b0;
        end
      end
      if (w_shift) begin
        r_shreg <= w_word;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_done) begin
        if (!r_chan) begin
          r_left_hold <= w_word;
          r_left_ok   <= 1'b1;
        end else begin
          r_left_ok <= 1'b0;
          if (r_left_ok) begin
            left  <= r_left_hold;
            right <= w_word;
            valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef AUDIO_IN_ERR_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_count <= '0;
    end else if (w_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_in.sv
// ============================================================================
// tb_audio_in : directed I2S streams against a left/right pair scoreboard.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_audio_in;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        CLK    = 1'b0;
  logic        RST    = 1'b1;
  logic        BCLK   = 1'b0;
  logic        LRCLK  = 1'b1;
  logic        ADCDAT = 1'b0;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic        frame_err;
`ifdef AUDIO_IN_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int    checks   = 0;
  int    failures = 0;
  int    errs     = 0;
  int    e0;
  pair_t sb_q[$];
  pair_t mon_exp;

  always #10 CLK = ~CLK;

  audio_in #(
    .SAMPLE_W    (16),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BCLK      (BCLK),
    .LRCLK     (LRCLK),
    .ADCDAT    (ADCDAT),
    .left      (left),
    .right     (right),
    .valid     (valid),
    .frame_err (frame_err)
`ifdef AUDIO_IN_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (frame_err) errs++;
    if (valid) begin
      chk("sb_expected_pending", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        chk("sb_left", {16'h0, left}, {16'h0, mon_exp.l});
        chk("sb_right", {16'h0, right}, {16'h0, mon_exp.r});
      end
    end
  end

  // Data and LRCLK change on the BCLK falling edge, captured on the rising edge.
  task automatic send_bit(input logic lr, input logic d);
    LRCLK  = lr;
    ADCDAT = d;
    BCLK   = 1'b0;
    #163;
    BCLK   = 1'b1;
    #163;
  endtask

  // Bit 0 is the delay bit, bits 1..16 carry the word MSB first, rest is filler.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic d;
      if (i >= 1 && i <= 16) d = w[16-i];
      else                   d = 1'($urandom_range(0, 1));
      send_bit(lr, d);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    sb_q.push_back(p);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() > 0 && n < 4000) begin
      @(posedge CLK);
      n++;
    end
    repeat (8) @(posedge CLK);
    chk(tag, sb_q.size(), 0);
  endtask

  task automatic pulse_rst(input int cycles);
    @(negedge CLK);
    RST = 1'b1;
    repeat (cycles) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("reset_left", {16'h0, left}, 32'h0);
    chk("reset_right", {16'h0, right}, 32'h0);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    RST = 1'b0;

    // Nominal 32-bit slots
    e0 = errs;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    push_pair(16'h8001, 16'h7FFE);
    send_slot(1'b0, 16'h8001, 32);
    send_slot(1'b1, 16'h7FFE, 32);
    drain("t1_drain");
    chk("t1_no_frame_err", errs - e0, 0);

    // Truncated left slot
    e0 = errs;
    send_slot(1'b0, 16'hAAAA, 10);
    send_slot(1'b1, 16'h5555, 32);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("t2_frame_err_count", errs - e0, 1);
    chk("t2_left_retained", {16'h0, left}, 32'h8001);
    chk("t2_right_retained", {16'h0, right}, 32'h7FFE);

    // Stream joined mid right slot
    pulse_rst(2);
    e0 = errs;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    push_pair(16'h1234, 16'hEDCB);
    send_slot(1'b0, 16'h1234, 32);
    send_slot(1'b1, 16'hEDCB, 32);
    drain("t3_drain");
    chk("t3_no_frame_err", errs - e0, 0);

    // Reset at left bit 8
    send_slot(1'b0, 16'hC3A5, 9);
    pulse_rst(1);
    chk("t4_rst_left", {16'h0, left}, 32'h0);
    chk("t4_rst_right", {16'h0, right}, 32'h0);
    chk("t4_rst_valid", {31'h0, valid}, 32'h0);
    for (int i = 9; i < 32; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    send_slot(1'b1, 16'h3C5A, 32);
    repeat (8) @(posedge CLK);
    chk("t4_no_valid_after_rst", sb_q.size(), 0);
    push_pair(16'h0F0F, 16'hF0F0);
    send_slot(1'b0, 16'h0F0F, 32);
    send_slot(1'b1, 16'hF0F0, 32);
    drain("t4_drain");

    // Minimum-length 17-BCLK slots
    e0 = errs;
    for (int f = 0; f < 4; f++) begin
      push_pair(16'hFFFF, 16'h0000);
      send_slot(1'b0, 16'hFFFF, 17);
      send_slot(1'b1, 16'h0000, 17);
    end
    drain("t5_drain");
    chk("t5_no_frame_err", errs - e0, 0);
    chk("t5_left_final", {16'h0, left}, 32'hFFFF);
    chk("t5_right_final", {16'h0, right}, 32'h0000);

`ifdef AUDIO_IN_ERR_CNT_EN
    pulse_rst(1);
    chk("t6_cnt_reset", {24'h0, err_count}, 32'h0);
    for (int i = 0; i < 2; i++) send_bit(1'b1, 1'b0);
    for (int s = 0; s < 301; s++) send_slot(1'(s % 2), 16'h0000, 3);
    repeat (10) @(posedge CLK);
    chk("t6_cnt_saturated", {24'h0, err_count}, 32'd255);
    for (int s = 301; s < 321; s++) send_slot(1'(s % 2), 16'h0000, 3);
    repeat (10) @(posedge CLK);
    chk("t6_cnt_holds", {24'h0, err_count}, 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
